// File: rtl/ext_mem_arb_pkg.sv
// Shared types and constants for the two-port external memory arbiter.
// Holds the FSM state encoding, port count and default timeout.
`timescale 1ns/1ps
package ext_mem_arb_pkg;

  localparam int NUM_PORTS       = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/ext_mem_arb_rr.sv
// rr_arb2: round-robin pick between two requesters plus last-grant register.
// Ports: i_clk, i_rst_n, i_req[1:0], i_upd (grant strobe), o_gnt (index), o_any.
`timescale 1ns/1ps
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic       o_gnt,
  output logic       o_any
);

  logic r_last;

  assign o_any = |i_req;

  // Contention goes to the port not served last.
  always_comb begin
    o_gnt = i_req[1];
    if (&i_req)
      o_gnt = ~r_last;
  end

  // Resets to 1 so port 0 wins the first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_last <= 1'b1;
    else if (i_upd && o_any)
      r_last <= o_gnt;
  end

endmodule

// File: rtl/ext_mem_arb.sv
// ext_mem_arb: two masters share one memory slave, one access at a time.
// Ports: clock/reset, m0_*/m1_* master ports, s_* slave port.
`timescale 1ns/1ps
module ext_mem_arb
  import ext_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    mem_clk_i,
  input  logic                    rst_n_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [ADDR_WIDTH/8-1:0] m0_sel_i,
  input  logic                    m0_wen_i,
  input  logic                    m0_ren_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_err_o,
  output logic                    m0_ack_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [ADDR_WIDTH/8-1:0] m1_sel_i,
  input  logic                    m1_wen_i,
  input  logic                    m1_ren_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_err_o,
  output logic                    m1_ack_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [ADDR_WIDTH/8-1:0] s_sel_o,
  output logic                    s_wen_o,
  output logic                    s_ren_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  input  logic                    s_err_i,
  input  logic                    s_ack_i
);

  localparam int SW = ADDR_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e                r_state;
  state_e                w_next;
  logic                  r_port;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_sel;
  logic                  r_wen;
  logic                  r_ren;
  logic                  r_err;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic [1:0]            w_req;
  logic                  w_gnt;
  logic                  w_any;
  logic                  w_upd;
  logic                  w_resp;
  logic                  w_wen;
  logic                  w_ren;
  logic                  w_tmo;
  logic                  w_done;
  logic                  w_cap;
  logic [DATA_WIDTH-1:0] w_cap_val;

  assign w_req = {m1_wen_i | m1_ren_i,
                  m0_wen_i | m0_ren_i};

  rr_arb2 u_rr (
    .i_clk   (mem_clk_i),
    .i_rst_n (rst_n_i),
    .i_req   (w_req),
    .i_upd   (w_upd),
    .o_gnt   (w_gnt),
    .o_any   (w_any)
  );

  assign w_wen = w_gnt ? m1_wen_i : m0_wen_i;
  assign w_ren = w_gnt ? m1_ren_i : m0_ren_i;

  assign w_tmo  = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_done = s_ack_i | w_tmo;

  // A timed-out read returns zero data.
  assign w_cap     = (r_state == S_WAIT) && w_done && r_ren;
  assign w_cap_val = s_ack_i ? s_rdata_i : '0;

  always_ff @(posedge mem_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_upd   = 1'b0;
    w_resp  = 1'b0;
    s_wen_o = 1'b0;
    s_ren_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_upd  = 1'b1;
          // Read+write together is illegal: answer with error, no slave access.
          w_next = (w_wen && w_ren) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        s_wen_o = r_wen;
        s_ren_o = r_ren;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (w_done)
          w_next = S_RESP;
      end
      S_RESP: begin
        w_resp = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_port   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sel    <= '0;
      r_wen    <= 1'b0;
      r_ren    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_port  <= w_gnt;
        r_addr  <= w_gnt ? m1_addr_i : m0_addr_i;
        r_wdata <= w_gnt ? m1_wdata_i : m0_wdata_i;
        r_sel   <= w_gnt ? m1_sel_i : m0_sel_i;
        r_wen   <= w_wen;
        r_ren   <= w_ren;
        r_err   <= w_wen & w_ren;
      end
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      if (r_state == S_WAIT) begin
        if (s_ack_i)
          r_err <= s_err_i;
        else if (w_tmo)
          r_err <= 1'b1;
        else
          r_cnt <= r_cnt + CW'(1);
      end
      if (w_cap && !r_port)
        r_rdata0 <= w_cap_val;
      if (w_cap && r_port)
        r_rdata1 <= w_cap_val;
    end
  end

  assign s_addr_o  = r_addr;
  assign s_wdata_o = r_wdata;
  assign s_sel_o   = r_sel;

  assign m0_ack_o   = w_resp & ~r_port;
  assign m1_ack_o   = w_resp & r_port;
  assign m0_err_o   = w_resp & ~r_port & r_err;
  assign m1_err_o   = w_resp & r_port & r_err;
  assign m0_rdata_o = r_rdata0;
  assign m1_rdata_o = r_rdata1;

endmodule

// File: tb/tb_ext_mem_arb.sv
// Testbench for ext_mem_arb: directed masters, memory model, response scoreboard.
// Expected responses are queued at request time and checked on each ack.
`timescale 1ns/1ps
module tb_ext_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [3:0]    m_sel   [2];
  logic          m_wen   [2];
  logic          m_ren   [2];
  logic [DW-1:0] m_rdata [2];
  logic          m_err   [2];
  logic          m_ack   [2];

  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_sel;
  logic          s_wen, s_ren;
  logic [DW-1:0] s_rdata;
  logic          s_err, s_ack_m, s_ack;
  logic          ack_en, late_ack;
  logic [31:0]   mem [16];

  assign s_ack = s_ack_m | late_ack;

  ext_mem_arb #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .mem_clk_i  (clk),
    .rst_n_i    (rst_n),
    .m0_addr_i  (m_addr[0]),
    .m0_wdata_i (m_wdata[0]),
    .m0_sel_i   (m_sel[0]),
    .m0_wen_i   (m_wen[0]),
    .m0_ren_i   (m_ren[0]),
    .m0_rdata_o (m_rdata[0]),
    .m0_err_o   (m_err[0]),
    .m0_ack_o   (m_ack[0]),
    .m1_addr_i  (m_addr[1]),
    .m1_wdata_i (m_wdata[1]),
    .m1_sel_i   (m_sel[1]),
    .m1_wen_i   (m_wen[1]),
    .m1_ren_i   (m_ren[1]),
    .m1_rdata_o (m_rdata[1]),
    .m1_err_o   (m_err[1]),
    .m1_ack_o   (m_ack[1]),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_sel_o    (s_sel),
    .s_wen_o    (s_wen),
    .s_ren_o    (s_ren),
    .s_rdata_i  (s_rdata),
    .s_err_i    (s_err),
    .s_ack_i    (s_ack)
  );

  // Memory slave: acks the cycle after the strobe; addr bit 31 low is out of range.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_m <= 1'b0;
      s_err   <= 1'b0;
      s_rdata <= '0;
    end else begin
      s_ack_m <= 1'b0;
      s_err   <= 1'b0;
      if (ack_en && (s_wen || s_ren)) begin
        s_ack_m <= 1'b1;
        if (!s_addr[31])
          s_err <= 1'b1;
        else if (s_ren)
          s_rdata <= mem[s_addr[5:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && ack_en && s_wen && s_addr[31])
      mem[s_addr[5:2]] <= s_wdata;
  end

  typedef struct {
    int          port;
    logic        err;
    logic        rd;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input int p, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] d);
    m_addr[p]  = a;
    m_wdata[p] = d;
    m_sel[p]   = 4'hF;
    m_wen[p]   = w;
    m_ren[p]   = r;
  endtask

  task automatic drop(input int p);
    m_wen[p] = 1'b0;
    m_ren[p] = 1'b0;
  endtask

  task automatic expect_rsp(input int p, input logic e, input logic rd,
                            input logic [31:0] d, input int lat);
    exp_t x;
    x.port  = p;
    x.err   = e;
    x.rd    = rd;
    x.rdata = d;
    x.cyc   = cyc + lat;
    sb.push_back(x);
  endtask

  // Waits (bounded) for the next ack, checks it against the queue head,
  // and drops the served master's request on the ack edge.
  task automatic serve(input string tag);
    exp_t x;
    int   n;
    int   p;
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 64'd1, 64'd0);
      return;
    end
    x = sb.pop_front();
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_ack[0] && !m_ack[1] && n < 64);
    if (!m_ack[0] && !m_ack[1]) begin
      chk({tag, "/ack_timeout"}, 64'd0, 64'd1);
      return;
    end
    p = m_ack[1] ? 1 : 0;
    chk({tag, "/port"}, 64'(p), 64'(x.port));
    chk({tag, "/cycle"}, 64'(cyc), 64'(x.cyc));
    chk({tag, "/err"}, 64'(m_err[p]), 64'(x.err));
    chk({tag, "/other"}, 64'({m_ack[1-p], m_err[1-p]}), 64'd0);
    if (x.rd)
      chk({tag, "/rdata"}, 64'(m_rdata[p]), 64'(x.rdata));
    drop(p);
  endtask

  initial begin
    int n;
    ack_en   = 1'b1;
    late_ack = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req(p, 1'b0, 1'b0, '0, '0);
      m_sel[p] = 4'h0;
    end

    tick();
    tick();
    chk("rst_ctl", 64'({m_ack[0], m_ack[1], m_err[0], m_err[1],
                        s_wen, s_ren}), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'd0);
    chk("rst_rdata", 64'({m_rdata[0], m_rdata[1]}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Contention right after reset: port 0 wins first.
    req(0, 1'b1, 1'b0, 32'h8000_0000, 32'h11);
    req(1, 1'b1, 1'b0, 32'h8000_0004, 32'h22);
    expect_rsp(0, 1'b0, 1'b0, '0, 3);
    expect_rsp(1, 1'b0, 1'b0, '0, 7);
    serve("cw0");
    serve("cw1");
    tick();

    req(0, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
    expect_rsp(0, 1'b0, 1'b0, '0, 3);
    serve("wr0");
    tick();

    // Single read with strobe timing.
    req(0, 1'b0, 1'b1, 32'h8000_0010, '0);
    expect_rsp(0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3);
    tick();
    chk("rd_issue", 64'({s_ren, s_wen}), 64'd2);
    chk("rd_addr", 64'(s_addr), 64'h8000_0010);
    tick();
    chk("rd_wait", 64'({s_ren, s_wen}), 64'd0);
    serve("rd0");
    tick();

    // Readback under contention; port 0 was served last, so port 1 first.
    req(0, 1'b0, 1'b1, 32'h8000_0000, '0);
    req(1, 1'b0, 1'b1, 32'h8000_0004, '0);
    expect_rsp(1, 1'b0, 1'b1, 32'h22, 3);
    expect_rsp(0, 1'b0, 1'b1, 32'h11, 7);
    serve("rb0");
    serve("rb1");
    tick();

    // Fairness: both keep re-requesting; grants alternate 1,0,1,0...
    req(0, 1'b0, 1'b1, 32'h8000_0000, '0);
    req(1, 1'b0, 1'b1, 32'h8000_0004, '0);
    for (int k = 0; k < 8; k++) begin
      int p;
      p = (k % 2 == 0) ? 1 : 0;
      expect_rsp(p, 1'b0, 1'b1, p ? 32'h22 : 32'h11, 3 + 4 * k);
    end
    for (int k = 0; k < 8; k++) begin
      int p;
      p = (k % 2 == 0) ? 1 : 0;
      serve("fair");
      if (k < 6)
        req(p, 1'b0, 1'b1, p ? 32'h8000_0004 : 32'h8000_0000, '0);
    end
    tick();

    // Out-of-range read on port 1.
    req(1, 1'b0, 1'b1, 32'h0000_0000, '0);
    expect_rsp(1, 1'b1, 1'b0, '0, 3);
    serve("aerr");
    chk("aerr_m0_rdata", 64'(m_rdata[0]), 64'h11);
    tick();

    // Read and write together: error straight from IDLE.
    req(1, 1'b1, 1'b1, 32'h8000_0008, 32'h33);
    expect_rsp(1, 1'b1, 1'b0, '0, 1);
    serve("rdwr");
    chk("rdwr_strobe", 64'({s_wen, s_ren}), 64'd0);
    tick();

    // Timeout with silent slave, then a stale ack.
    ack_en = 1'b0;
    req(0, 1'b0, 1'b1, 32'h8000_0000, '0);
    expect_rsp(0, 1'b1, 1'b1, '0, 2 + TO);
    serve("tmo");
    late_ack = 1'b1;
    tick();
    tick();
    late_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_ack[0] || m_ack[1])
        n++;
    end
    chk("late_ack", 64'(n), 64'd0);
    ack_en = 1'b1;

    // Reset during WAIT.
    req(0, 1'b0, 1'b1, 32'h8000_0004, '0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({m_ack[0], m_ack[1], m_err[0], m_err[1],
                            s_wen, s_ren}), 64'd0);
    chk("mid_rst_addr", 64'(s_addr), 64'd0);
    chk("mid_rst_rdata", 64'({m_rdata[0], m_rdata[1]}), 64'd0);
    drop(0);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_ack[0] || m_ack[1])
        n++;
    end
    chk("post_rst_quiet", 64'(n), 64'd0);
    req(0, 1'b0, 1'b1, 32'h8000_0004, '0);
    expect_rsp(0, 1'b0, 1'b1, 32'h22, 3);
    serve("post_rst");
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
